decode_reg_select: RTL and testbench
====================================

// Module: decode_reg_select
// PURPOSE
//  Y86-64 decode-stage register-ID selection: derives source IDs (srcA/srcB) and destination IDs (dstE/dstM) from D_icode/D_rA/D_rB.
//  Combinational d_* outputs feed the register-file read ports and the forwarding logic (sel+fwd A, fwd B).
//  A D->E pipeline register captures the same IDs for the execute stage.
// PARAMETERS
//  REG_NONE  4'hF  "no register" ID
//  REG_RSP   4'h4  stack-pointer ID
// PORTS
//  clk       in   1  single clock, all state on rising edge
//  reset     in   1  synchronous, active-high
//  D_icode   in   4  decode-stage instruction code
//  D_rA      in   4  decode-stage rA field
//  D_rB      in   4  decode-stage rB field
//  E_stall   in   1  hold E_* registers
//  E_bubble  in   1  load REG_NONE into E_* registers (inject nop)
//  d_srcA    out  4  comb. source A ID
//  d_srcB    out  4  comb. source B ID
//  d_dstE    out  4  comb. ALU-result destination ID
//  d_dstM    out  4  comb. memory-result destination ID
//  E_srcA/E_srcB/E_dstE/E_dstM  out  4 each  registered copies for execute
// BEHAVIOUR
//  icodes: HALT 0, NOP 1, RRMOVQ/CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
//  d_srcA = D_rA for {2,4,6,A}; REG_RSP for {9,B}; else REG_NONE.
//  d_srcB = D_rB for {4,5,6}; REG_RSP for {8,9,A,B}; else REG_NONE.
//  d_dstE = D_rB for {2,3,6}; REG_RSP for {8,9,A,B}; else REG_NONE.
//   Cmov condition is not applied here; execute overrides dstE.
//  d_dstM = D_rA for {5,B}; else REG_NONE.
//  Unknown/illegal icode (C..F without feature): all four d_* = REG_NONE.
//  d_* are purely combinational, zero latency; no dependence on clk.
//  E_* update on rising clk; priority reset > E_bubble > E_stall > load d_*.
//  Reset: all E_* = REG_NONE. Reset asserted mid-operation clears on that edge.
//  bubble+stall together: bubble wins.
//  rA/rB of REG_NONE pass through unchanged (F in, F out).
//  Latency D->E_*: 1 cycle.
// CONFIGURATION
//  IADDQ_EN defined: icode C (IADDQ) supported: d_srcB = D_rB, d_dstE = D_rB, d_srcA = d_dstM = REG_NONE.
//  IADDQ_EN undefined: icode C treated as illegal (all REG_NONE).
// STRUCTURE
//  Shared package y86_pkg: icode constants (I_HALT..I_POPQ, I_IADDQ), REG_RSP, REG_NONE, reg_id_t (4-bit).
//  One sub-module reg_id_mux: three-way select (rX / RSP / NONE) driven by two one-hot enables.
//  Instantiated four times (srcA, srcB, dstE, dstM); E_* register in top.
// TESTING
//  OPQ icode 6, rA=2, rB=3 -> d_srcA=2 d_srcB=3 d_dstE=3 d_dstM=F; next edge E_* equal.
//  POPQ icode B, rA=7 -> d_srcA=4 d_srcB=4 d_dstE=4 d_dstM=7.
//  MRMOVQ icode 5, rA=1, rB=5 -> srcA=F srcB=5 dstE=F dstM=1.
//  CALL 8 -> srcA=F srcB=4 dstE=4 dstM=F; HALT/NOP/JXX -> all F.
//  reset=1 with OPQ loaded -> E_* all F after edge; E_bubble=1 -> E_* F; E_stall=1 -> E_* hold prior values.
//  icode C: IADDQ_EN set, rB=9 -> srcB=9 dstE=9 srcA=dstM=F; unset -> all F.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: icode constants, special register IDs and ID bundle type.
package y86_pkg;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t REG_NONE = 4'hF;
  localparam reg_id_t REG_RSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  typedef struct packed {
    reg_id_t src_a;
    reg_id_t src_b;
    reg_id_t dst_e;
    reg_id_t dst_m;
  } reg_ids_t;

  localparam reg_ids_t IDS_NONE = '{REG_NONE, REG_NONE, REG_NONE, REG_NONE};

endpackage

// File: rtl/reg_id_mux.sv
// Three-way register-ID select: instruction field, stack pointer, or "no register".
module reg_id_mux
  import y86_pkg::*;
(
  input  reg_id_t rx,
  input  logic    sel_rx,
  input  logic    sel_rsp,
  output reg_id_t id
);

  // Enables are one-hot or both low; both low selects REG_NONE.
  always_comb begin
    id = REG_NONE;
    if (sel_rx) begin
      id = rx;
    end else if (sel_rsp) begin
      id = REG_RSP;
    end
  end

endmodule

// File: rtl/decode_reg_select.sv
// Y86-64 decode-stage source/destination register-ID selection with D->E pipeline register.
// Optional macro IADDQ_EN adds icode C (IADDQ) decoding.
module decode_reg_select
  import y86_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic [3:0] D_icode,
  input  reg_id_t D_rA,
  input  reg_id_t D_rB,
  input  logic    E_stall,
  input  logic    E_bubble,
  output reg_id_t d_srcA,
  output reg_id_t d_srcB,
  output reg_id_t d_dstE,
  output reg_id_t d_dstM,
  output reg_id_t E_srcA,
  output reg_id_t E_srcB,
  output reg_id_t E_dstE,
  output reg_id_t E_dstM
);

  logic a_rx, a_rsp;
  logic b_rx, b_rsp;
  logic e_rx, e_rsp;
  logic m_rx;

  always_comb begin
    a_rx  = 1'b0;
    a_rsp = 1'b0;
    b_rx  = 1'b0;
    b_rsp = 1'b0;
    e_rx  = 1'b0;
    e_rsp = 1'b0;
    m_rx  = 1'b0;
    case (D_icode)
      I_RRMOVQ: begin a_rx = 1'b1; e_rx = 1'b1; end
      I_IRMOVQ: e_rx = 1'b1;
      I_RMMOVQ: begin a_rx = 1'b1; b_rx = 1'b1; end
      I_MRMOVQ: begin b_rx = 1'b1; m_rx = 1'b1; end
      I_OPQ:    begin a_rx = 1'b1; b_rx = 1'b1; e_rx = 1'b1; end
      I_CALL:   begin b_rsp = 1'b1; e_rsp = 1'b1; end
      I_RET:    begin a_rsp = 1'b1; b_rsp = 1'b1; e_rsp = 1'b1; end
      I_PUSHQ:  begin a_rx = 1'b1; b_rsp = 1'b1; e_rsp = 1'b1; end
      I_POPQ:   begin a_rsp = 1'b1; b_rsp = 1'b1; e_rsp = 1'b1; m_rx = 1'b1; end
`ifdef IADDQ_EN
      I_IADDQ:  begin b_rx = 1'b1; e_rx = 1'b1; end
`endif
      default: ;
    endcase
  end

  reg_id_mux u_src_a (.rx(D_rA), .sel_rx(a_rx), .sel_rsp(a_rsp), .id(d_srcA));
  reg_id_mux u_src_b (.rx(D_rB), .sel_rx(b_rx), .sel_rsp(b_rsp), .id(d_srcB));
  reg_id_mux u_dst_e (.rx(D_rB), .sel_rx(e_rx), .sel_rsp(e_rsp), .id(d_dstE));
  reg_id_mux u_dst_m (.rx(D_rA), .sel_rx(m_rx), .sel_rsp(1'b0),  .id(d_dstM));

  reg_ids_t e_ids_q;

  // Bubble outranks stall so a squashed slot never holds a stale instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_ids_q <= IDS_NONE;
    end else if (E_bubble) begin
      e_ids_q <= IDS_NONE;
    end else if (!E_stall) begin
      e_ids_q <= '{d_srcA, d_srcB, d_dstE, d_dstM};
    end
  end

  assign E_srcA = e_ids_q.src_a;
  assign E_srcB = e_ids_q.src_b;
  assign E_dstE = e_ids_q.dst_e;
  assign E_dstM = e_ids_q.dst_m;

endmodule

// File: tb/tb_decode_reg_select.sv
// Self-checking bench for decode_reg_select: combinational IDs checked directly, E_* via scoreboard.
module tb_decode_reg_select;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D_icode, D_rA, D_rB;
  logic       E_stall, E_bubble;
  logic [3:0] d_srcA, d_srcB, d_dstE, d_dstM;
  logic [3:0] E_srcA, E_srcB, E_dstE, E_dstM;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] sb_q[$];
  logic [15:0] e_exp;

  always #5 clk = ~clk;

  decode_reg_select dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_rA(D_rA), .D_rB(D_rB),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got srcA/srcB/dstE/dstM=%h, expected %h", tag, got, exp);
    end
  endtask

  // Reference decode, written from the icode tables: {srcA, srcB, dstE, dstM}.
  function automatic logic [15:0] model(input logic [3:0] ic, input logic [3:0] ra,
                                        input logic [3:0] rb);
    logic [3:0] sa, sb, de, dm;
    sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
    else if (ic inside {4'h9, 4'hB}) sa = 4'h4;
    if (ic inside {4'h4, 4'h5, 4'h6}) sb = rb;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'h4;
    if (ic inside {4'h2, 4'h3, 4'h6}) de = rb;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
    if (ic inside {4'h5, 4'hB}) dm = ra;
`ifdef IADDQ_EN
    if (ic == 4'hC) begin sb = rb; de = rb; end
`endif
    return {sa, sb, de, dm};
  endfunction

  task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input logic rst, input logic bub, input logic stl);
    logic [15:0] d_exp;
    D_icode = ic; D_rA = ra; D_rB = rb;
    reset = rst; E_bubble = bub; E_stall = stl;
    #1;
    d_exp = model(ic, ra, rb);
    check({tag, "_d"}, {d_srcA, d_srcB, d_dstE, d_dstM}, d_exp);
    if (rst || bub) e_exp = 16'hFFFF;
    else if (!stl) e_exp = d_exp;
    sb_q.push_back(e_exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL %s_e: scoreboard empty", tag);
    end else begin
      check({tag, "_e"}, {E_srcA, E_srcB, E_dstE, E_dstM}, sb_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    D_icode = 4'h0; D_rA = 4'h0; D_rB = 4'h0;

    step("reset",   4'h6, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0);
    check("reset_state", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'hFFFF);
    step("opq",     4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    check("opq_e_lit", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'h233F);
    step("popq",    4'hB, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0);
    check("popq_e_lit", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'h4447);
    step("mrmovq",  4'h5, 4'h1, 4'h5, 1'b0, 1'b0, 1'b0);
    check("mrmovq_e_lit", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'hF5F1);
    step("call",    4'h8, 4'h3, 4'h6, 1'b0, 1'b0, 1'b0);
    check("call_e_lit", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'hF44F);
    step("halt",    4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    step("nop",     4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    step("jxx",     4'h7, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    step("rrmovq",  4'h2, 4'h8, 4'h9, 1'b0, 1'b0, 1'b0);
    step("irmovq",  4'h3, 4'hF, 4'hA, 1'b0, 1'b0, 1'b0);
    step("rmmovq",  4'h4, 4'hC, 4'hD, 1'b0, 1'b0, 1'b0);
    step("ret",     4'h9, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    step("pushq",   4'hA, 4'hE, 4'hF, 1'b0, 1'b0, 1'b0);
    step("none_pt", 4'h6, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    step("iaddq",   4'hC, 4'h2, 4'h9, 1'b0, 1'b0, 1'b0);
    step("ill_d",   4'hD, 4'h2, 4'h9, 1'b0, 1'b0, 1'b0);
    step("ill_f",   4'hF, 4'h2, 4'h9, 1'b0, 1'b0, 1'b0);

    // Pipeline-control priorities.
    step("load",    4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    step("stall",   4'hB, 4'h7, 4'h0, 1'b0, 1'b0, 1'b1);
    check("stall_hold_lit", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'h233F);
    step("stall2",  4'h8, 4'h7, 4'h0, 1'b0, 1'b0, 1'b1);
    step("bubble",  4'h6, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0);
    step("reload",  4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    step("bub_stl", 4'hB, 4'h7, 4'h0, 1'b0, 1'b1, 1'b1);
    step("reload2", 4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    step("rst_mid", 4'hB, 4'h7, 4'h0, 1'b1, 1'b0, 1'b1);
    check("rst_mid_lit", {E_srcA, E_srcB, E_dstE, E_dstM}, 16'hFFFF);

    for (int i = 0; i < 60; i++) begin
      step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
    end

    if (sb_q.size() != 0) begin
      tests_run++; tests_failed++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
